// File: rtl/mmcm_lock_ctrl_pkg.sv
// Shared types and constants for the MMCM lock controller.
package mmcm_lock_pkg;

  typedef enum logic [2:0] {
    ASSERT_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_e;

  localparam int RETRY_W         = 4;
  localparam int LOL_W           = 8;
  localparam int LOCK_FILTER_LEN = 4;

  // Width of a counter that must reach (largest of the three limits) - 1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mmcm_lock_ctrl_sync_2ff.sv
// Single-bit two-flop synchronizer; output resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of an asynchronous level into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let both stages sample pre-edge values, forming a real 2-flop chain.
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mmcm_lock_ctrl.sv
// MMCM reset / lock-qualification controller.
// Pulses mmcm_reset, waits for lock with timeout and bounded retries,
// qualifies lock stability, then releases the downstream reset.
// Optional build macro MMCM_LOCK_FILTER_EN: in RUN, a loss of lock is only
// declared after LOCK_FILTER_LEN consecutive low synchronized-lock cycles.
module mmcm_lock_ctrl
  import mmcm_lock_pkg::*;
#(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 65536,
  parameter int STABLE_CYCLES    = 256,
  parameter int MAX_RETRIES      = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               locked_in,
  input  logic               relock_req,
  output logic               mmcm_reset,
  output logic               sys_reset_n,
  output logic               ready,
  output logic               fail,
  output logic [RETRY_W-1:0] retry_count,
  output logic [LOL_W-1:0]   lol_count
);

  localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [RETRY_W-1:0] RETRY_SAT    = '1;
  localparam logic [LOL_W-1:0]   LOL_SAT      = '1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic [LOL_W-1:0]   lol_q, lol_d;
  logic               mmcm_reset_q, mmcm_reset_d;
  logic               sys_reset_n_q, sys_reset_n_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               lock_s;
  logic               lock_lost;

  sync_2ff u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (locked_in),
    .q       (lock_s)
  );

`ifdef MMCM_LOCK_FILTER_EN
  localparam int FLT_W = $clog2(LOCK_FILTER_LEN);
  logic [FLT_W-1:0] low_cnt_q, low_cnt_d;

  // Count consecutive low lock cycles in RUN; declare loss on the last one.
  always_comb begin
    low_cnt_d = '0;
    lock_lost = 1'b0;
    if (state_q == RUN && !lock_s) begin
      if (low_cnt_q == FLT_W'(LOCK_FILTER_LEN - 1)) lock_lost = 1'b1;
      else                                          low_cnt_d = low_cnt_q + 1'b1;
    end
  end

  // Loss-of-lock filter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) low_cnt_q <= '0;
    else          low_cnt_q <= low_cnt_d;
  end
`else
  // Any single low lock cycle in RUN is a loss of lock.
  always_comb lock_lost = !lock_s;
`endif

  // Next-state, counters and next registered outputs.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_d   = retry_q;
    lol_d     = lol_q;
    retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;

    case (state_q)
      ASSERT_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle still wins.
        if (lock_s) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          if (MAX_RETRIES != 0 && retry_inc == RETRY_LIMIT) state_d = FAIL;
          else                                              state_d = ASSERT_RST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = ASSERT_RST;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (lock_lost) begin
          state_d = ASSERT_RST;
          cnt_d   = '0;
          if (lol_q != LOL_SAT) lol_d = lol_q + 1'b1;
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = ASSERT_RST;
        cnt_d   = '0;
      end
    endcase

    // Relock overrides the sequence but never hides a coincident loss count.
    if (relock_req) begin
      state_d = ASSERT_RST;
      cnt_d   = '0;
      retry_d = '0;
    end

    mmcm_reset_d  = (state_d == ASSERT_RST) || (state_d == FAIL);
    sys_reset_n_d = (state_d == RUN);
    ready_d       = (state_d == RUN);
    fail_d        = (state_d == FAIL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ASSERT_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      lol_q         <= '0;
      mmcm_reset_q  <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      lol_q         <= lol_d;
      mmcm_reset_q  <= mmcm_reset_d;
      sys_reset_n_q <= sys_reset_n_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
    end
  end

  assign mmcm_reset  = mmcm_reset_q;
  assign sys_reset_n = sys_reset_n_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign lol_count   = lol_q;

endmodule

// File: tb/tb_mmcm_lock_ctrl.sv
// Self-checking bench for mmcm_lock_ctrl (RST=4, TIMEOUT=32, STABLE=8, RETRIES=3).
module tb_mmcm_lock_ctrl;

  logic       clk;
  logic       reset_n;
  logic       locked_in;
  logic       relock_req;
  logic       mmcm_reset;
  logic       sys_reset_n;
  logic       ready;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lol_count;

  mmcm_lock_ctrl #(
    .RST_PULSE_CYCLES (4),
    .LOCK_TIMEOUT     (32),
    .STABLE_CYCLES    (8),
    .MAX_RETRIES      (3)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .locked_in   (locked_in),
    .relock_req  (relock_req),
    .mmcm_reset  (mmcm_reset),
    .sys_reset_n (sys_reset_n),
    .ready       (ready),
    .fail        (fail),
    .retry_count (retry_count),
    .lol_count   (lol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One table row: hold inputs for n cycles, expecting the packed outputs after each edge.
  typedef struct {
    int          n;
    logic        lk;
    logic        rl;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          row_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        seen_ready;
  logic [15:0] sb_exp;
  int          sb_row;

  function automatic logic [15:0] pk(input logic mr, input logic srn, input logic rdy,
                                     input logic fl, input logic [3:0] rc, input logic [7:0] lc);
    return {mr, srn, rdy, fl, rc, lc};
  endfunction

  function automatic logic [15:0] outs();
    return {mmcm_reset, sys_reset_n, ready, fail, retry_count, lol_count};
  endfunction

  function automatic vec_t mk(input int n, input logic lk, input logic rl, input logic [15:0] e);
    vec_t v;
    v.n = n; v.lk = lk; v.rl = rl; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Advance n cycles, landing 1 time unit after the edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) seen_ready = 1'b1;
    end
  endtask

  // Number of consecutive samples (starting now) with mmcm_reset at val.
  task automatic count_run(input logic val, input int budget, output int n);
    n = 0;
    while (mmcm_reset === val && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_ready(input logic val, input int budget, output logic ok);
    int n;
    n = 0;
    while (ready !== val && n < budget) begin
      tick(1);
      n++;
    end
    ok = (ready === val);
  endtask

  // Scoreboard: compare the oldest pending expectation after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      sb_row = row_q.pop_front();
      check($sformatf("vec_row_%0d", sb_row), 32'(outs()), 32'(sb_exp));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic ok;
    reset_n    = 1'b0;
    locked_in  = 1'b0;
    relock_req = 1'b0;
    seen_ready = 1'b0;

    // Nominal bring-up: lock rises 10 cycles after mmcm_reset falls.
    vecs.push_back(mk(3,  1'b0, 1'b0, pk(1, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(11, 1'b0, 1'b0, pk(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(10, 1'b1, 1'b0, pk(0, 0, 0, 0, 0, 0)));
    vecs.push_back(mk(5,  1'b1, 1'b0, pk(0, 1, 1, 0, 0, 0)));
`ifdef MMCM_LOCK_FILTER_EN
    // One-cycle drop is filtered; a four-cycle drop is a loss.
    vecs.push_back(mk(1,  1'b0, 1'b0, pk(0, 1, 1, 0, 0, 0)));
    vecs.push_back(mk(6,  1'b1, 1'b0, pk(0, 1, 1, 0, 0, 0)));
    vecs.push_back(mk(4,  1'b0, 1'b0, pk(0, 1, 1, 0, 0, 0)));
    vecs.push_back(mk(1,  1'b1, 1'b0, pk(0, 1, 1, 0, 0, 0)));
`else
    // One-cycle drop is a loss.
    vecs.push_back(mk(1,  1'b0, 1'b0, pk(0, 1, 1, 0, 0, 0)));
    vecs.push_back(mk(1,  1'b1, 1'b0, pk(0, 1, 1, 0, 0, 0)));
`endif
    vecs.push_back(mk(4,  1'b1, 1'b0, pk(1, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(9,  1'b1, 1'b0, pk(0, 0, 0, 0, 0, 1)));
    vecs.push_back(mk(3,  1'b1, 1'b0, pk(0, 1, 1, 0, 0, 1)));

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0)));
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      for (int j = 0; j < vecs[i].n; j++) begin
        locked_in  = vecs[i].lk;
        relock_req = vecs[i].rl;
        exp_q.push_back(vecs[i].exp);
        row_q.push_back(i);
        @(posedge clk);
        #2;
      end
    end
    check("scoreboard_drained", exp_q.size(), 0);

    // Never locks: three timeouts, then terminal failure.
    locked_in = 1'b0;
    reset_n   = 1'b0;
    tick(1);
    check("reset_pulse", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0)));
    reset_n = 1'b1;
    tick(3);
    check("first_pulse_high", mmcm_reset, 1);
    tick(1);
    check("first_pulse_low", mmcm_reset, 0);
    for (int k = 1; k <= 3; k++) begin
      count_run(1'b0, 100, n);
      check($sformatf("timeout_len_%0d", k), n, 32);
      check($sformatf("retry_after_%0d", k), retry_count, k);
      if (k < 3) begin
        count_run(1'b1, 20, n);
        check($sformatf("retry_pulse_%0d", k), n, 4);
      end
    end
    check("fail_state", 32'(outs()), 32'(pk(1, 0, 0, 1, 3, 0)));
    tick(5);
    check("fail_holds", 32'(outs()), 32'(pk(1, 0, 0, 1, 3, 0)));

    // Relock from FAIL.
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    check("relock_clears", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0)));
    count_run(1'b1, 20, n);
    check("relock_pulse", n, 4);

    // One timeout so the glitch test has a nonzero retry_count to preserve.
    count_run(1'b0, 100, n);
    check("timeout_again", n, 32);
    check("retry_one", retry_count, 1);
    count_run(1'b1, 20, n);
    check("pulse_again", n, 4);

    // Stability glitch: 5 good STABLE cycles, then one low cycle.
    seen_ready = 1'b0;
    locked_in  = 1'b1;
    tick(5);
    locked_in = 1'b0;
    tick(1);
    locked_in = 1'b1;
    tick(1);
    check("glitch_still_stable", mmcm_reset, 0);
    tick(1);
    check("glitch_restart", 32'(outs()), 32'(pk(1, 0, 0, 0, 1, 0)));
    check("glitch_no_ready", seen_ready, 0);

    // Lock observed exactly on the counter==31 cycle.
    locked_in = 1'b0;
    count_run(1'b1, 20, n);
    check("pre_late_pulse", n, 4);
    tick(29);
    locked_in = 1'b1;
    tick(3);
    check("late_lock_stable", 32'(outs()), 32'(pk(0, 0, 0, 0, 1, 0)));
    tick(7);
    check("late_lock_not_yet", 32'(outs()), 32'(pk(0, 0, 0, 0, 1, 0)));
    tick(1);
    check("late_lock_run", 32'(outs()), 32'(pk(0, 1, 1, 0, 0, 0)));

    // 256 loss events: lol_count saturates at 255.
    for (int i = 0; i < 256; i++) begin
      wait_ready(1'b1, 60, ok);
      if (!ok) begin
        check("sat_wait_up", ready, 1);
        break;
      end
      locked_in = 1'b0;
      wait_ready(1'b0, 20, ok);
      if (!ok) begin
        check("sat_wait_down", ready, 0);
        break;
      end
      locked_in = 1'b1;
      check($sformatf("lol_event_%0d", i), lol_count, (i + 1 > 255) ? 255 : i + 1);
    end

    // Async reset while in STABLE.
    wait_ready(1'b1, 60, ok);
    if (!ok) check("final_wait_up", ready, 1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(6);
    check("stable_before_reset", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 255)));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", 32'(outs()), 32'(pk(1, 0, 0, 0, 0, 0)));
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("resume_pulse_high", mmcm_reset, 1);
    tick(1);
    check("resume_pulse_low", mmcm_reset, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
